// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray-code counter with clear, Gray-coded load, wrap/saturate
// bounds and a terminal-count pulse. Define GCNT_CHECK_EN to add the Gray-integrity checker.
module gray_counter_param #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0,
  parameter int RST_VAL  = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_gray_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             tc_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] MAX_BIN  = '1;
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // A step off either bound is a terminal-count event in both modes; only the
  // landing value differs (wrap to the opposite bound or stay put).
  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (clr_i) begin
      bin_d = '0;
    end else if (load_i) begin
      bin_d = gray2bin(load_gray_i);
    end else if (en_i) begin
      if (up_i) begin
        if (bin_q == MAX_BIN) begin
          tc_d  = 1'b1;
          bin_d = (SATURATE != 0) ? bin_q : '0;
        end else begin
          bin_d = bin_q + WIDTH'(1);
        end
      end else begin
        if (bin_q == '0) begin
          tc_d  = 1'b1;
          bin_d = (SATURATE != 0) ? bin_q : MAX_BIN;
        end else begin
          bin_d = bin_q - WIDTH'(1);
        end
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bin_o  = bin_q;
  assign gray_o = gray_q;
  assign tc_o   = tc_q;

`ifdef GCNT_CHECK_EN
  // shadow_q holds the previous gray_o; step_q marks that the last edge was a
  // pure step or hold, so the transition shadow_q -> gray_q must change <= 1 bit.
  logic [WIDTH-1:0] shadow_q;
  logic             step_q;
  logic             err_q;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;

  assign diff      = shadow_q ^ gray_q;
  assign multi_bit = (diff & (diff - WIDTH'(1))) != '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= RST_GRAY;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= gray_q;
      step_q   <= !clr_i && !load_i;
      err_q    <= err_q | (step_q & multi_bit);
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: four instances share stimulus and are checked every
// cycle against an integer model; directed literal checks pin the model.
module tb_gray_counter_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [15:0] lg = '0;

  logic [3:0] g0, b0, g1, b1, g2, b2;
  logic [6:0] g3, b3;
  logic       t0, t1, t2, t3, e0, e1, e2, e3;

  int tests = 0;
  int fails = 0;

  localparam int WV[4] = '{4, 4, 4, 7};
  localparam int SV[4] = '{0, 1, 0, 1};
  localparam int RV[4] = '{0, 0, 5, 100};

  int   mb[4]   = '{0, 0, 5, 100};
  logic mtc[4]  = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic merr[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(4), .SATURATE(0), .RST_VAL(0)) u0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
    .load_gray_i(lg[3:0]), .gray_o(g0), .bin_o(b0), .tc_o(t0), .err_o(e0));
  gray_counter_param #(.WIDTH(4), .SATURATE(1), .RST_VAL(0)) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
    .load_gray_i(lg[3:0]), .gray_o(g1), .bin_o(b1), .tc_o(t1), .err_o(e1));
  gray_counter_param #(.WIDTH(4), .SATURATE(0), .RST_VAL(5)) u2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
    .load_gray_i(lg[3:0]), .gray_o(g2), .bin_o(b2), .tc_o(t2), .err_o(e2));
  gray_counter_param #(.WIDTH(7), .SATURATE(1), .RST_VAL(100)) u3 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
    .load_gray_i(lg[6:0]), .gray_o(g3), .bin_o(b3), .tc_o(t3), .err_o(e3));

  // Inverse Gray by search: the value whose Gray encoding matches g.
  function automatic int g2b(input int g, input int w);
    for (int v = 0; v < (1 << w); v++) begin
      if ((v ^ (v >> 1)) == g) return v;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 4; k++) begin
      int mx, nb;
      mx = (1 << WV[k]) - 1;
      if (rst) begin
        mb[k] = RV[k]; mtc[k] = 1'b0; merr[k] = 1'b0;
      end else if (clr) begin
        mb[k] = 0; mtc[k] = 1'b0;
      end else if (load) begin
        mb[k] = g2b(int'(lg) & mx, WV[k]); mtc[k] = 1'b0;
      end else if (en) begin
        nb = up ? mb[k] + 1 : mb[k] - 1;
        if (nb < 0 || nb > mx) begin
          mtc[k] = 1'b1;
          mb[k]  = (SV[k] != 0) ? mb[k] : (up ? 0 : mx);
        end else begin
          mtc[k] = 1'b0;
          mb[k]  = nb;
        end
      end else begin
        mtc[k] = 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input int k, input logic [15:0] g, input logic [15:0] b,
                     input logic tc, input logic err);
    check($sformatf("u%0d bin", k), b, 16'(mb[k]));
    check($sformatf("u%0d gray", k), g, 16'(mb[k] ^ (mb[k] >> 1)));
    check($sformatf("u%0d tc", k), 16'(tc), 16'(mtc[k]));
    check($sformatf("u%0d err", k), 16'(err), 16'(merr[k]));
  endtask

  always @(negedge clk) begin
    cmp(0, 16'(g0), 16'(b0), t0, e0);
    cmp(1, 16'(g1), 16'(b1), t1, e1);
    cmp(2, 16'(g2), 16'(b2), t2, e2);
    cmp(3, 16'(g3), 16'(b3), t3, e3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    check("rst u0 bin", 16'(b0), 16'd0);
    check("rst u0 tc", 16'(t0), 16'd0);
    check("rst u2 bin", 16'(b2), 16'd5);
    check("rst u2 gray", 16'(g2), 16'b0111);

    // up-count through the wrap
    rst = 1'b0; en = 1'b1; up = 1'b1;
    repeat (15) tick();
    check("up bin15", 16'(b0), 16'd15);
    check("up gray15", 16'(g0), 16'b1000);
    check("up tc before wrap", 16'(t0), 16'd0);
    tick();
    check("wrap bin0", 16'(b0), 16'd0);
    check("wrap gray0", 16'(g0), 16'd0);
    check("wrap tc", 16'(t0), 16'd1);

    // down-count through the wrap, then to 5
    up = 1'b0;
    tick();
    check("down wrap bin", 16'(b0), 16'd15);
    check("down wrap gray", 16'(g0), 16'b1000);
    check("down wrap tc", 16'(t0), 16'd1);
    repeat (10) tick();
    check("down bin5", 16'(b0), 16'd5);
    check("down gray5", 16'(g0), 16'b0111);
    check("down tc0", 16'(t0), 16'd0);

    // load beats enable; clear beats load
    load = 1'b1; lg = 16'h000C; en = 1'b1;
    tick();
    check("load bin", 16'(b0), 16'd8);
    check("load gray", 16'(g0), 16'b1100);
    check("load tc", 16'(t0), 16'd0);
    clr = 1'b1;
    tick();
    check("clr over load", 16'(b0), 16'd0);
    clr = 1'b0; load = 1'b0;

    // saturate at max
    up = 1'b1;
    repeat (15) tick();
    check("sat bin15", 16'(b1), 16'd15);
    check("sat tc0", 16'(t1), 16'd0);
    repeat (3) begin
      tick();
      check("sat hold bin", 16'(b1), 16'd15);
      check("sat hold tc", 16'(t1), 16'd1);
    end
    up = 1'b0;
    tick();
    check("sat away bin", 16'(b1), 16'd14);
    check("sat away tc", 16'(t1), 16'd0);

    // asynchronous reset mid-cycle
    clr = 1'b1; tick(); clr = 1'b0; up = 1'b1;
    repeat (9) tick();
    check("pre-rst u2 bin", 16'(b2), 16'd9);
    #2 rst = 1'b1;
    #1;
    check("async rst bin", 16'(b2), 16'd5);
    check("async rst gray", 16'(g2), 16'b0111);
    check("async rst tc", 16'(t2), 16'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post-rst bin", 16'(b2), 16'd6);

    // randomized traffic
    repeat (600) begin
      rst  = ($urandom_range(0, 199) == 0);
      clr  = ($urandom_range(0, 29) == 0);
      load = ($urandom_range(0, 19) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1) != 0;
      lg   = 16'($urandom);
      tick();
    end
    rst = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0;
    tick();

`ifdef GCNT_CHECK_EN
    tick();
    u0.shadow_q = u0.shadow_q ^ 4'b0011;
    tick();
    merr[0] = 1'b1;
    check("err set", 16'(e0), 16'd1);
    en = 1'b1;
    repeat (3) tick();
    check("err sticky", 16'(e0), 16'd1);
    en = 1'b0; rst = 1'b1;
    tick();
    check("err cleared", 16'(e0), 16'd0);
    rst = 1'b0;
    tick();
`endif

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
    $finish;
  end

endmodule
